// File: rtl/fft_iter_pkg.sv
// Shared definitions for the iterative FFT address path: widths, state
// encoding and the bit-reversal helper.
package fft_iter_pkg;

  localparam int LAYERS_DEF  = 5;
  localparam int BUTT_WL_DEF = LAYERS_DEF - 1;
  localparam int MAX_ADDR_WL = 16;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Data-memory address width for a given butterfly-counter width.
  function automatic int addr_wl(input int butt_wl);
    return butt_wl + 1;
  endfunction

  // Reverse the low 'width' bits of x; bits above 'width' return as 0.
  function automatic logic [MAX_ADDR_WL-1:0] bitrev(input logic [MAX_ADDR_WL-1:0] x,
                                                    input int unsigned width);
    logic [MAX_ADDR_WL-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_ADDR_WL; i++) begin
      if (i < int'(width)) begin
        r[i] = x[int'(width) - 1 - i];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/addr_gen_fft_iter_if.sv
// Control-unit handshake and memory-address bundle of the FFT address generator.
interface addr_gen_fft_iter_if #(
  parameter int LayWL  = 3,
  parameter int ButtWL = 4
) ();

  logic              start;
  logic              addr_en;
  logic [ButtWL:0]   addr_a;
  logic [ButtWL:0]   addr_b;
  logic [ButtWL-1:0] tw_idx;
  logic [LayWL-1:0]  lay;
  logic [ButtWL-1:0] but;
  logic              first;
  logic              last_lay;
  logic              busy;
  logic              done;

  modport master (
    output start, addr_en,
    input  addr_a, addr_b, tw_idx, lay, but, first, last_lay, busy, done
  );

  modport slave (
    input  start, addr_en,
    output addr_a, addr_b, tw_idx, lay, but, first, last_lay, busy, done
  );

endinterface

// File: rtl/fft_bfly_addr_decode.sv
// Combinational decode of (layer, butterfly) into the two in-place data
// addresses and the twiddle ROM index.
module fft_bfly_addr_decode
  import fft_iter_pkg::*;
#(
  parameter int LAYERS       = 5,
  parameter int LayWL        = 3,
  parameter int ButtWL       = 4,
  parameter int BITREV_FIRST = 1,
  localparam int AW          = ButtWL + 1
) (
  input  logic [LayWL-1:0]  lay,
  input  logic [ButtWL-1:0] but,
  output logic [AW-1:0]     addr_a,
  output logic [AW-1:0]     addr_b,
  output logic [ButtWL-1:0] tw_idx
);

  logic [ButtWL-1:0] mask;
  logic [ButtWL-1:0] j;
  logic [AW-1:0]     a_nat;
  logic [AW-1:0]     b_nat;

  always_comb begin
    // On the last layer 1<<lay wraps to 0 and the mask becomes all ones.
    mask  = (ButtWL'(1) << lay) - ButtWL'(1);
    j     = but & mask;
    // Insert a zero at bit 'lay': upper bits move up one place, j stays put.
    a_nat = ({1'b0, but & ~mask} << 1) | {1'b0, j};
    b_nat = a_nat | (AW'(1) << lay);
    tw_idx = j << (LayWL'(LAYERS - 1) - lay);

    addr_a = a_nat;
    addr_b = b_nat;
    if ((BITREV_FIRST != 0) && (lay == '0)) begin
      addr_a = AW'(bitrev(MAX_ADDR_WL'(a_nat), AW));
      addr_b = AW'(bitrev(MAX_ADDR_WL'(b_nat), AW));
    end
  end

endmodule

// File: rtl/addr_gen_fft_iter.sv
// Butterfly address generator for the iterative radix-2 in-place FFT:
// walks layer/butterfly counters on ADDR_EN and registers the decoded addresses.
module addr_gen_fft_iter
  import fft_iter_pkg::*;
#(
  parameter int LAYERS       = 5,
  parameter int LayWL        = 3,
  parameter int ButtWL       = 4,
  parameter int BITREV_FIRST = 1
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               EN,
  addr_gen_fft_iter_if.slave bus
);

  localparam int AW = ButtWL + 1;
  localparam logic [ButtWL-1:0] BUT_MAX = '1;
  localparam logic [LayWL-1:0]  LAY_MAX = LayWL'(LAYERS - 1);

  state_t            state_reg, state_next;
  logic [LayWL-1:0]  lay_reg, lay_next;
  logic [ButtWL-1:0] but_reg, but_next;
  logic              done_reg, done_next;

  logic [AW-1:0]     addr_a_reg, addr_b_reg;
  logic [ButtWL-1:0] tw_idx_reg;
  logic              first_reg, last_lay_reg, busy_reg;

  logic [AW-1:0]     dec_a, dec_b;
  logic [ButtWL-1:0] dec_tw;

  always_comb begin
    state_next = state_reg;
    lay_next   = lay_reg;
    but_next   = but_reg;
    done_next  = done_reg;
    // With EN low everything, including a pending DONE, is held.
    if (EN) begin
      done_next = 1'b0;
      if (bus.start) begin
        state_next = ST_RUN;
        lay_next   = '0;
        but_next   = '0;
      end else if ((state_reg == ST_RUN) && bus.addr_en) begin
        if (but_reg == BUT_MAX) begin
          but_next = '0;
          if (lay_reg == LAY_MAX) begin
            state_next = ST_IDLE;
            lay_next   = '0;
            done_next  = 1'b1;
          end else begin
            lay_next = lay_reg + LayWL'(1);
          end
        end else begin
          but_next = but_reg + ButtWL'(1);
        end
      end
    end
  end

  // Decode runs on next-counter values so addresses land with the counters.
  fft_bfly_addr_decode #(
    .LAYERS       (LAYERS),
    .LayWL        (LayWL),
    .ButtWL       (ButtWL),
    .BITREV_FIRST (BITREV_FIRST)
  ) u_decode (
    .lay    (lay_next),
    .but    (but_next),
    .addr_a (dec_a),
    .addr_b (dec_b),
    .tw_idx (dec_tw)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg    <= ST_IDLE;
      lay_reg      <= '0;
      but_reg      <= '0;
      done_reg     <= 1'b0;
      addr_a_reg   <= '0;
      addr_b_reg   <= '0;
      tw_idx_reg   <= '0;
      first_reg    <= 1'b0;
      last_lay_reg <= 1'b0;
      busy_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      lay_reg      <= lay_next;
      but_reg      <= but_next;
      done_reg     <= done_next;
      busy_reg     <= (state_next == ST_RUN);
      first_reg    <= (state_next == ST_RUN) && (lay_next == '0);
      last_lay_reg <= (state_next == ST_RUN) && (lay_next == LAY_MAX);
      if (state_next == ST_RUN) begin
        addr_a_reg <= dec_a;
        addr_b_reg <= dec_b;
        tw_idx_reg <= dec_tw;
      end else begin
        addr_a_reg <= '0;
        addr_b_reg <= '0;
        tw_idx_reg <= '0;
      end
    end
  end

  assign bus.addr_a   = addr_a_reg;
  assign bus.addr_b   = addr_b_reg;
  assign bus.tw_idx   = tw_idx_reg;
  assign bus.lay      = lay_reg;
  assign bus.but      = but_reg;
  assign bus.first    = first_reg;
  assign bus.last_lay = last_lay_reg;
  assign bus.busy     = busy_reg;
  assign bus.done     = done_reg;

endmodule

// File: tb/tb_addr_gen_fft_iter.sv
// Scoreboard bench for addr_gen_fft_iter: a bit-reversed and a natural-order
// instance share one stimulus stream and are checked against a reference model.
module tb_addr_gen_fft_iter;

  localparam int LAYERS = 5;
  localparam int BUTTS  = 16;

  logic CLK = 1'b0;
  logic RST;
  logic EN;

  always #5 CLK = ~CLK;

  addr_gen_fft_iter_if #(.LayWL(3), .ButtWL(4)) bus_rev ();
  addr_gen_fft_iter_if #(.LayWL(3), .ButtWL(4)) bus_nat ();

  addr_gen_fft_iter #(.LAYERS(5), .LayWL(3), .ButtWL(4), .BITREV_FIRST(1)) dut_rev (
    .CLK (CLK),
    .RST (RST),
    .EN  (EN),
    .bus (bus_rev)
  );

  addr_gen_fft_iter #(.LAYERS(5), .LayWL(3), .ButtWL(4), .BITREV_FIRST(0)) dut_nat (
    .CLK (CLK),
    .RST (RST),
    .EN  (EN),
    .bus (bus_nat)
  );

  typedef struct {
    int unsigned a_rev, b_rev, a_nat, b_nat, tw, lay, but;
    bit          first, last, busy, done;
  } exp_t;

  exp_t exp_q[$];

  bit m_busy = 1'b0;
  bit m_done = 1'b0;
  int m_lay  = 0;
  int m_but  = 0;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp_v, $time);
    end
  endtask

  function automatic int unsigned bitrev5(input int unsigned x);
    int unsigned r = 0;
    for (int i = 0; i < LAYERS; i++) begin
      if (x[i]) r |= (1 << (LAYERS - 1 - i));
    end
    return r;
  endfunction

  // Reference pair address by group/offset arithmetic.
  function automatic int unsigned ref_a(input int s, input int b);
    int unsigned span = 1 << s;
    return (b / span) * (2 * span) + (b % span);
  endfunction

  task automatic model_step(input bit st, input bit ae, input bit en, input bit rs);
    if (rs) begin
      m_busy = 0; m_done = 0; m_lay = 0; m_but = 0;
    end else if (en) begin
      m_done = 0;
      if (st) begin
        m_busy = 1; m_lay = 0; m_but = 0;
      end else if (m_busy && ae) begin
        if (m_but == BUTTS - 1) begin
          m_but = 0;
          if (m_lay == LAYERS - 1) begin
            m_busy = 0; m_lay = 0; m_done = 1;
          end else begin
            m_lay++;
          end
        end else begin
          m_but++;
        end
      end
    end
  endtask

  task automatic cyc(input bit st, input bit ae, input bit en, input bit rs);
    exp_t e;
    RST = rs;
    EN  = en;
    bus_rev.start = st; bus_rev.addr_en = ae;
    bus_nat.start = st; bus_nat.addr_en = ae;
    model_step(st, ae, en, rs);
    e.busy  = m_busy;
    e.done  = m_done;
    e.lay   = m_lay;
    e.but   = m_but;
    e.first = m_busy && (m_lay == 0);
    e.last  = m_busy && (m_lay == LAYERS - 1);
    if (m_busy) begin
      e.a_nat = ref_a(m_lay, m_but);
      e.b_nat = e.a_nat + (1 << m_lay);
      e.a_rev = (m_lay == 0) ? bitrev5(e.a_nat) : e.a_nat;
      e.b_rev = (m_lay == 0) ? bitrev5(e.b_nat) : e.b_nat;
      e.tw    = (m_but % (1 << m_lay)) * (1 << (LAYERS - 1 - m_lay));
    end else begin
      e.a_nat = 0; e.b_nat = 0; e.a_rev = 0; e.b_rev = 0; e.tw = 0;
    end
    exp_q.push_back(e);
    @(posedge CLK);
    #1;
    e = exp_q.pop_front();
    chk("addr_a",   32'(bus_rev.addr_a),   e.a_rev);
    chk("addr_b",   32'(bus_rev.addr_b),   e.b_rev);
    chk("tw_idx",   32'(bus_rev.tw_idx),   e.tw);
    chk("lay",      32'(bus_rev.lay),      e.lay);
    chk("but",      32'(bus_rev.but),      e.but);
    chk("first",    32'(bus_rev.first),    32'(e.first));
    chk("last_lay", 32'(bus_rev.last_lay), 32'(e.last));
    chk("busy",     32'(bus_rev.busy),     32'(e.busy));
    chk("done",     32'(bus_rev.done),     32'(e.done));
    chk("nat_a",    32'(bus_nat.addr_a),   e.a_nat);
    chk("nat_b",    32'(bus_nat.addr_b),   e.b_nat);
    $display("cyc t=%0t st=%0b ae=%0b en=%0b rst=%0b -> lay=%0d but=%0d a=%0d b=%0d tw=%0d busy=%0b done=%0b",
             $time, st, ae, en, rs, bus_rev.lay, bus_rev.but, bus_rev.addr_a,
             bus_rev.addr_b, bus_rev.tw_idx, bus_rev.busy, bus_rev.done);
  endtask

  initial begin
    int guard;
    RST = 1'b1;
    EN  = 1'b0;
    bus_rev.start = 1'b0; bus_rev.addr_en = 1'b0;
    bus_nat.start = 1'b0; bus_nat.addr_en = 1'b0;

    cyc(0, 0, 0, 1);
    cyc(0, 0, 1, 1);
    chk("rst_busy", 32'(bus_rev.busy), 0);
    chk("rst_addr_b", 32'(bus_rev.addr_b), 0);

    cyc(1, 0, 1, 0);
    chk("start_a", 32'(bus_rev.addr_a), 0);
    chk("start_b", 32'(bus_rev.addr_b), 16);
    chk("start_first", 32'(bus_rev.first), 1);
    chk("start_busy", 32'(bus_rev.busy), 1);

    cyc(0, 1, 1, 0);
    chk("l0b1_a", 32'(bus_rev.addr_a), 8);
    chk("l0b1_b", 32'(bus_rev.addr_b), 24);
    chk("l0b1_nat_a", 32'(bus_nat.addr_a), 2);
    chk("l0b1_nat_b", 32'(bus_nat.addr_b), 3);

    repeat (36) cyc(0, 1, 1, 0);
    chk("l2b5_a", 32'(bus_rev.addr_a), 9);
    chk("l2b5_b", 32'(bus_rev.addr_b), 13);
    chk("l2b5_tw", 32'(bus_rev.tw_idx), 4);
    chk("l2b5_lay", 32'(bus_rev.lay), 2);

    repeat (42) cyc(0, 1, 1, 0);
    chk("l4b15_a", 32'(bus_rev.addr_a), 15);
    chk("l4b15_b", 32'(bus_rev.addr_b), 31);
    chk("l4b15_tw", 32'(bus_rev.tw_idx), 15);
    chk("l4b15_last", 32'(bus_rev.last_lay), 1);

    cyc(0, 1, 1, 0);
    chk("final_done", 32'(bus_rev.done), 1);
    chk("final_busy", 32'(bus_rev.busy), 0);
    chk("final_a", 32'(bus_rev.addr_a), 0);

    // DONE must survive an EN-low stretch.
    repeat (3) cyc(0, 0, 0, 0);
    chk("done_hold", 32'(bus_rev.done), 1);
    cyc(0, 0, 1, 0);
    chk("done_clear", 32'(bus_rev.done), 0);

    repeat (4) cyc(0, 1, 1, 0);
    chk("idle_ae_but", 32'(bus_rev.but), 0);

    // Full transform with random gaps and freezes.
    cyc(1, 0, 1, 0);
    guard = 0;
    while (m_busy && guard < 3000) begin
      cyc(0, 1'($urandom_range(0, 1)), ($urandom_range(0, 4) != 0), 0);
      guard++;
    end
    chk("rand_busy_end", 32'(bus_rev.busy), 0);
    chk("rand_timeout", 32'(guard < 3000), 1);
    repeat (3) cyc(0, 0, 1, 0);

    // START and RST in the middle of layer 3.
    cyc(1, 0, 1, 0);
    repeat (52) cyc(0, 1, 1, 0);
    chk("mid_lay", 32'(bus_rev.lay), 3);
    cyc(1, 1, 1, 0);
    chk("restart_but", 32'(bus_rev.but), 0);
    chk("restart_b", 32'(bus_rev.addr_b), 16);
    repeat (52) cyc(0, 1, 1, 0);
    cyc(0, 1, 1, 1);
    chk("mid_rst_busy", 32'(bus_rev.busy), 0);
    chk("mid_rst_done", 32'(bus_rev.done), 0);
    repeat (3) cyc(0, 1, 1, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/addr_gen_fft_iter.md
# addr_gen_fft_iter

Butterfly address generator for the iterative radix-2 in-place FFT core. It consumes the butterfly-advance strobe issued by the FFT control unit and produces, for every butterfly of every layer, the two data-memory addresses (read, then write back in place), the twiddle ROM index and layer status flags. It sits between the control unit and the dual-port data RAM / twiddle ROM and is the consumer side of the control unit's ADDR_EN/FIRST interface.

## Interface
- LAYERS, 5, number of FFT layers; N = 2^LAYERS points
- LayWL, 3, layer counter width; must hold LAYERS
- ButtWL, 4, butterfly counter width; must equal LAYERS-1 (N/2 butterflies per layer)
- BITREV_FIRST, 1, 1 = layer-0 addresses are bit-reversed (input stored in natural order); 0 = natural addressing on all layers

- CLK  in  1  clock; all state updates on rising edge
- RST  in  1  reset, synchronous, active-high; overrides every other input
- EN  in  1  global enable; when 0 all state frozen (RST still acts)
- START  in  1  begin a new transform (restarts if BUSY)
- ADDR_EN  in  1  retire current butterfly, advance to next
- ADDR_A  out  ButtWL+1  upper-wing address of current butterfly
- ADDR_B  out  ButtWL+1  lower-wing address of current butterfly
- TW_IDX  out  ButtWL  twiddle ROM index
- LAY  out  LayWL  current layer 0..LAYERS-1
- BUT  out  ButtWL  current butterfly 0..N/2-1
- FIRST  out  1  LAY == 0 and BUSY
- LAST_LAY  out  1  LAY == LAYERS-1 and BUSY
- BUSY  out  1  transform in progress
- DONE  out  1  one-cycle pulse after last butterfly retired

## Operation
- Reset values: all outputs 0; counters 0.
- States: IDLE (BUSY=0), RUN (BUSY=1). IDLE→RUN on START&EN; RUN→IDLE on ADDR_EN&EN at BUT=N/2-1, LAY=LAYERS-1 (DONE=1 same edge); RUN→RUN with counters cleared on START&EN.
- ADDR_EN with EN in RUN: BUT+1; at BUT=N/2-1, BUT→0 and LAY+1. ADDR_EN in IDLE ignored.
- Start and ADDR_EN in same cycle: START wins, counters cleared.
- Decode for layer s, butterfly b: j = b mod 2^s; natural A = insert 0 at bit s of b, i.e. ((b>>s)<<(s+1)) | j; B = A | 2^s; TW_IDX = j << (LAYERS-1-s), truncated to ButtWL.
- If BITREV_FIRST=1 and s=0: ADDR_A = bitrev(A), ADDR_B = bitrev(B) over ButtWL+1 bits. TW_IDX=0 on layer 0 regardless.
- In IDLE ADDR_A, ADDR_B, TW_IDX, LAY, BUT hold 0.
- All arithmetic unsigned, no overflow possible within legal parameter range.

## Timing
- All outputs registered; decode computed from next-counter values so outputs and counters update on the same edge.
- START at edge k → BUSY=1, FIRST=1, butterfly (0,0) addresses valid from k+1.
- ADDR_EN at edge k → next butterfly addresses valid from k+1; current addresses stable from previous advance until ADDR_EN, so the same pair serves read and in-place write.
- Final ADDR_EN at edge k → DONE=1, BUSY=0, addresses 0 during k+1 only; DONE low at k+2.
- RST mid-transform → all outputs 0 next cycle, no DONE.
- EN=0: outputs hold; DONE pulse, if present, is held until EN returns (no lost pulse).

## Structure
- Shared package fft_iter_pkg: address width (ButtWL+1), bitrev function, state encoding constants for IDLE/RUN.
- One natural sub-module: fft_bfly_addr_decode (combinational, s,b → A,B,TW_IDX, with bit reversal option); instantiated once on next-counter values.

## Test plan
- Reset, defaults (N=32, BITREV_FIRST=1): all outputs 0; START → ADDR_A=0, ADDR_B=16, FIRST=1, BUSY=1.
- Layer 0 walk: one ADDR_EN after START → ADDR_A=8, ADDR_B=24 (bitrev of 2,3); with BITREV_FIRST=0 → 2,3.
- Layer 2, b=5 (reached after 37 ADDR_EN) → ADDR_A=9, ADDR_B=13, TW_IDX=4, LAY=2.
- Layer 4, b=15 (79 ADDR_EN) → ADDR_A=15, ADDR_B=31, TW_IDX=15, LAST_LAY=1; 80th ADDR_EN → DONE one cycle, BUSY=0, outputs 0.
- Gaps and freeze: random idle cycles and EN=0 periods between ADDR_EN; ADDR_EN while IDLE → no change; full sequence matches reference model address list.
- START and RST mid-layer-3: START → back to (0,0), ADDR_B=16; RST → all 0, no DONE pulse.
